binned_centroid: RTL and testbench

- Sits directly downstream of the 4x4 mask binning stage.
- Consumes the binned 1-bit mask stream (binned coordinates plus valid) and accumulates, per frame, the pixel count and the x and y coordinate sums.
- At frame end it divides the sums by the count with a sequential divider and emits the mask centroid for crosshair/tracking logic.

---
 rtl/binned_centroid_pkg.sv | 27 ++
 rtl/binned_centroid_seq_divider.sv | 70 +++++++
 rtl/binned_centroid.sv | 164 ++++++++++++++++
 tb/tb_binned_centroid.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/binned_centroid_pkg.sv
// Shared types and width helpers for the binned mask centroid block.
package binned_centroid_pkg;

    // Top-level sequencing: accumulate, divide x, divide y, report.
    typedef enum logic [1:0] {
        IDLE_ACC,
        DIV_X,
        DIV_Y,
        REPORT
    } stateT;

    // Pixel counter width: must hold a completely set frame.
    function automatic int calcCw(input int hres, input int vres);
        return $clog2(hres * vres + 1);
    endfunction

    // Column sum width: count times the largest column.
    function automatic int calcXw(input int hres, input int vres);
        return calcCw(hres, vres) + $clog2(hres);
    endfunction

    // Row sum width: count times the largest row.
    function automatic int calcYw(input int hres, input int vres);
        return calcCw(hres, vres) + $clog2(vres);
    endfunction

endpackage

// File: rtl/binned_centroid_seq_divider.sv
// Restoring divider producing one quotient bit per clock. The run length is
// chosen per operation so a narrower dividend finishes sooner; the first
// quotient bit is resolved on the start edge itself, so done and the final
// quotient appear exactly i_len cycles after start.
module seq_divider #(
    parameter int DW = 25,
    parameter int SW = 16,
    localparam int LW = $clog2(DW + 1)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [SW-1:0] i_divisor,
    input  logic [LW-1:0] i_len,
    output logic [DW-1:0] o_quotient,
    output logic          o_done,
    output logic          o_busy
);

    logic [SW-1:0] r_rem;
    logic [DW-1:0] r_quo;
    logic [SW-1:0] r_div;
    logic [LW-1:0] r_cnt;
    logic          r_done;

    logic [LW-1:0] w_shift;
    logic [LW-1:0] w_cntIn;
    logic [SW-1:0] w_remIn;
    logic [DW-1:0] w_quoIn;
    logic [SW-1:0] w_divIn;
    logic [SW:0]   w_shifted;
    logic [SW:0]   w_diff;
    logic          w_fits;

    // The dividend is left-justified so its top significant bit is consumed first.
    assign w_shift   = LW'(DW) - i_len;
    assign w_cntIn   = i_start ? i_len : r_cnt;
    assign w_remIn   = i_start ? '0 : r_rem;
    assign w_quoIn   = i_start ? (i_dividend << w_shift) : r_quo;
    assign w_divIn   = i_start ? i_divisor : r_div;
    assign w_shifted = {w_remIn, w_quoIn[DW-1]};
    assign w_fits    = (w_shifted >= {1'b0, w_divIn});
    assign w_diff    = w_shifted - {1'b0, w_divIn};

    // One restoring step per clock; start loads operands and performs the first step.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start || (r_cnt != '0)) begin
                r_rem  <= w_fits ? SW'(w_diff) : SW'(w_shifted);
                r_quo  <= {w_quoIn[DW-2:0], w_fits};
                r_div  <= w_divIn;
                r_cnt  <= w_cntIn - LW'(1);
                r_done <= (w_cntIn == LW'(1));
            end
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;
    assign o_busy     = (r_cnt != '0);

endmodule

// File: rtl/binned_centroid.sv
// Accumulates per-frame mask pixel count and coordinate sums from the binned
// stream, then divides them on one shared divider to report the centroid.
module binned_centroid
    import binned_centroid_pkg::*;
#(
    parameter int HRES      = 320,
    parameter int VRES      = 180,
    parameter int MIN_COUNT = 1,
    localparam int HW = $clog2(HRES),
    localparam int VW = $clog2(VRES),
    localparam int CW = calcCw(HRES, VRES),
    localparam int XW = calcXw(HRES, VRES),
    localparam int YW = calcYw(HRES, VRES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [HW-1:0] hcount_in,
    input  logic [VW-1:0] vcount_in,
    input  logic          pixel_data_in,
    input  logic          data_valid_in,
    output logic [HW-1:0] x_out,
    output logic [VW-1:0] y_out,
    output logic [CW-1:0] count_out,
    output logic          found_out,
    output logic          valid_out,
    output logic          busy_out,
    output logic          overrun_out
);

    localparam logic [HW-1:0] H_LAST  = HW'(HRES - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(VRES - 1);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_COUNT);
    localparam int            LW      = $clog2(XW + 1);

    stateT r_state, w_nextState;

    logic [CW-1:0] r_accCount, w_nextCount, r_snapCount;
    logic [XW-1:0] r_accX, w_nextX, r_snapX;
    logic [YW-1:0] r_accY, w_nextY, r_snapY;

    logic w_accept, w_inc, w_frameEnd, w_goDivide;

    logic          r_divStart;
    logic [XW-1:0] w_dividend;
    logic [LW-1:0] w_divLen;
    logic [XW-1:0] w_quotient;
    logic          w_divDone;
    logic          w_divBusy;

    logic [HW-1:0] r_xRes;
    logic [HW-1:0] r_xOut;
    logic [VW-1:0] r_yOut;
    logic [CW-1:0] r_countOut;
    logic          r_foundOut;
    logic          r_overrun;

    // Only valid in-range pixels count; the last raster position closes the frame.
    assign w_accept    = data_valid_in && (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
    assign w_inc       = w_accept && pixel_data_in;
    assign w_frameEnd  = w_accept && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    assign w_nextCount = r_accCount + CW'(w_inc);
    assign w_nextX     = r_accX + (w_inc ? XW'(hcount_in) : '0);
    assign w_nextY     = r_accY + (w_inc ? YW'(vcount_in) : '0);
    assign w_goDivide  = (w_nextCount >= MIN_CNT) && (w_nextCount != '0);

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= IDLE_ACC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: divide only when the frame has enough pixels.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE_ACC: if (w_frameEnd) w_nextState = w_goDivide ? DIV_X : REPORT;
            DIV_X:    if (w_divDone) w_nextState = DIV_Y;
            DIV_Y:    if (w_divDone) w_nextState = REPORT;
            REPORT:   w_nextState = IDLE_ACC;
            default:  w_nextState = IDLE_ACC;
        endcase
    end

    // Live accumulators restart at every frame end, even if the frame is discarded.
    always_ff @(posedge clk_in) begin
        if (!rst_in || w_frameEnd) begin
            r_accCount <= '0;
            r_accX     <= '0;
            r_accY     <= '0;
        end else begin
            r_accCount <= w_nextCount;
            r_accX     <= w_nextX;
            r_accY     <= w_nextY;
        end
    end

    // Snapshot, divider sequencing and result registers; all outputs change together.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_snapCount <= '0;
            r_snapX     <= '0;
            r_snapY     <= '0;
            r_divStart  <= 1'b0;
            r_xRes      <= '0;
            r_xOut      <= '0;
            r_yOut      <= '0;
            r_countOut  <= '0;
            r_foundOut  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun  <= w_frameEnd && (r_state != IDLE_ACC);
            r_divStart <= ((w_nextState == DIV_X) && (r_state != DIV_X)) ||
                          ((w_nextState == DIV_Y) && (r_state != DIV_Y));
            if ((r_state == IDLE_ACC) && w_frameEnd) begin
                r_snapCount <= w_nextCount;
                r_snapX     <= w_nextX;
                r_snapY     <= w_nextY;
                if (!w_goDivide) begin
                    r_countOut <= w_nextCount;
                    r_foundOut <= (w_nextCount >= MIN_CNT);
                end
            end
            if ((r_state == DIV_X) && w_divDone) begin
                r_xRes <= HW'(w_quotient);
            end
            if ((r_state == DIV_Y) && w_divDone) begin
                r_xOut     <= r_xRes;
                r_yOut     <= VW'(w_quotient);
                r_countOut <= r_snapCount;
                r_foundOut <= 1'b1;
            end
        end
    end

    assign w_dividend = (r_state == DIV_Y) ? XW'(r_snapY) : r_snapX;
    assign w_divLen   = (r_state == DIV_Y) ? LW'(YW) : LW'(XW);

    seq_divider #(
        .DW (XW),
        .SW (CW)
    ) u_divider (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_start    (r_divStart),
        .i_dividend (w_dividend),
        .i_divisor  (r_snapCount),
        .i_len      (w_divLen),
        .o_quotient (w_quotient),
        .o_done     (w_divDone),
        .o_busy     (w_divBusy)
    );

    assign x_out       = r_xOut;
    assign y_out       = r_yOut;
    assign count_out   = r_countOut;
    assign found_out   = r_foundOut;
    assign valid_out   = (r_state == REPORT);
    assign busy_out    = (r_state == DIV_X) || (r_state == DIV_Y) || w_divBusy;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_binned_centroid.sv
// Directed bench for binned_centroid at the default 320x180 geometry.
module tb_binned_centroid;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [8:0]  hcount_in;
    logic [7:0]  vcount_in;
    logic        pixel_data_in;
    logic        data_valid_in;
    logic [8:0]  x_out;
    logic [7:0]  y_out;
    logic [15:0] count_out;
    logic        found_out;
    logic        valid_out;
    logic        busy_out;
    logic        overrun_out;

    int checks = 0;
    int errors = 0;
    int validPulses = 0;
    int busySeen = 0;
    int savedPulses;

    binned_centroid dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .pixel_data_in (pixel_data_in),
        .data_valid_in (data_valid_in),
        .x_out         (x_out),
        .y_out         (y_out),
        .count_out     (count_out),
        .found_out     (found_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .overrun_out   (overrun_out)
    );

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    // Tally report pulses and busy cycles away from the active edge.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) validPulses++;
        if (busy_out === 1'b1) busySeen++;
    end

    // Hard stop in case anything wedges.
    initial begin
        #20000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int h, input int v, input logic d, input logic vld);
        @(negedge clk_in);
        hcount_in     = 9'(h);
        vcount_in     = 8'(v);
        pixel_data_in = d;
        data_valid_in = vld;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
            pixel_data_in = 1'b0;
        end
    endtask

    task automatic waitValid(input int maxC, output int lat);
        lat = 0;
        for (int i = 1; i <= maxC && lat == 0; i++) begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
            pixel_data_in = 1'b0;
            if (valid_out === 1'b1) lat = i;
        end
    endtask

    task automatic checkReport(input string tag, input int expLat, input int expCount,
                               input int expX, input int expY, input logic expFound);
        int lat;
        waitValid(expLat + 10, lat);
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " count"}, count_out, expCount);
        checkOutput({tag, " x"}, x_out, expX);
        checkOutput({tag, " y"}, y_out, expY);
        checkOutput({tag, " found"}, found_out, expFound);
        @(negedge clk_in);
        checkOutput({tag, " valid width"}, valid_out, 0);
    endtask

    initial begin
        hcount_in     = '0;
        vcount_in     = '0;
        pixel_data_in = 1'b0;
        data_valid_in = 1'b0;
        $display("[TB] starting binned_centroid directed test");

        // Reset state
        repeat (3) @(negedge clk_in);
        checkOutput("reset x", x_out, 0);
        checkOutput("reset y", y_out, 0);
        checkOutput("reset count", count_out, 0);
        checkOutput("reset found", found_out, 0);
        checkOutput("reset valid", valid_out, 0);
        checkOutput("reset busy", busy_out, 0);
        checkOutput("reset overrun", overrun_out, 0);
        rst_in = 1'b1;

        // Empty frame: reported one cycle after frame end, no division
        busySeen = 0;
        for (int h = 0; h < 8; h++) applyStimulus(h, 0, 1'b0, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        checkReport("empty", 1, 0, 0, 0, 1'b0);
        checkOutput("empty busy cycles", busySeen, 0);

        // 2x2 block at columns 10-11, rows 20-21
        applyStimulus(10, 20, 1'b1, 1'b1);
        applyStimulus(11, 20, 1'b1, 1'b1);
        applyStimulus(10, 21, 1'b1, 1'b1);
        applyStimulus(11, 21, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        checkReport("block", 52, 4, 10, 20, 1'b1);

        // Right-edge column with invalid and out-of-range pixels mixed in
        applyStimulus(319, 0, 1'b1, 1'b1);
        applyStimulus(319, 0, 1'b1, 1'b0);
        applyStimulus(400, 0, 1'b1, 1'b1);
        applyStimulus(319, 1, 1'b1, 1'b1);
        applyStimulus(319, 1, 1'b1, 1'b0);
        applyStimulus(319, 200, 1'b1, 1'b1);
        applyStimulus(400, 179, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b1, 1'b0);
        applyStimulus(319, 179, 1'b0, 1'b1);
        checkReport("edge", 52, 2, 319, 0, 1'b1);

        // Back-to-back frames: the second frame's pixel arrives right after frame end
        applyStimulus(5, 7, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        applyStimulus(300, 170, 1'b1, 1'b1);
        checkReport("b2b first", 51, 1, 5, 7, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        checkReport("b2b second", 52, 1, 300, 170, 1'b1);

        // Every pixel set
        for (int v = 0; v < 180; v++)
            for (int h = 0; h < 320; h++)
                applyStimulus(h, v, 1'b1, 1'b1);
        checkReport("full", 52, 57600, 159, 89, 1'b1);

        // Early frame end during the y division
        applyStimulus(100, 50, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        idleCycles(29);
        checkOutput("overrun busy", busy_out, 1);
        applyStimulus(200, 100, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("overrun pulse", overrun_out, 1);
        idleCycles(1);
        checkOutput("overrun width", overrun_out, 0);
        checkReport("overrun inflight", 19, 1, 100, 50, 1'b1);
        savedPulses = validPulses;
        idleCycles(80);
        checkOutput("overrun discarded", validPulses - savedPulses, 0);
        applyStimulus(3, 4, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        checkReport("after overrun", 52, 1, 3, 4, 1'b1);

        // Reset in the middle of the x division
        applyStimulus(50, 60, 1'b1, 1'b1);
        applyStimulus(319, 179, 1'b0, 1'b1);
        idleCycles(10);
        checkOutput("midreset busy", busy_out, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        checkOutput("midreset x", x_out, 0);
        checkOutput("midreset y", y_out, 0);
        checkOutput("midreset count", count_out, 0);
        checkOutput("midreset found", found_out, 0);
        checkOutput("midreset busy clear", busy_out, 0);
        rst_in = 1'b1;
        savedPulses = validPulses;
        idleCycles(70);
        checkOutput("midreset no report", validPulses - savedPulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
